sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Parametrised rectangle blitter for the VGA game datapath. It copies a W×H image from one of NUM_SRC synchronous colour ROMs, or fills it with black, to the VGA plotter at a programmable origin, at one pixel per clock. Off-screen pixels are clipped. It replaces the fixed full-screen and 40×40 sprite counter/mux arrangement with a single start/done-driven engine that the game FSM kicks once per screen or sprite.

## Interface
Parameters:
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOR_W, 3, colour bits per pixel
- ADDR_W, 15, ROM address width (covers 160×120 = 19200)
- NUM_SRC, 8, number of ROM source channels
- SEL_W, 3, width of src_sel (≥ clog2(NUM_SRC))
- TRANSPARENT, 3'b000, transparency key colour (used only with macro)

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- fill  in  1  1 = black fill, 0 = ROM copy; latched on start
- src_sel  in  SEL_W  ROM channel; latched on start
- x0  in  X_W  origin x; latched on start
- y0  in  Y_W  origin y; latched on start
- w  in  X_W  rectangle width; latched on start
- h  in  Y_W  rectangle height; latched on start
- mem_addr  out  ADDR_W  shared address to all ROMs
- mem_data  in  NUM_SRC*COLOR_W  ROM outputs concatenated; channel k at [k*COLOR_W +: COLOR_W]; 1-cycle read latency
- x  out  X_W  plot x
- y  out  Y_W  plot y
- color  out  COLOR_W  plot colour
- plot  out  1  write enable to VGA adapter
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at completion

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE → RUN when start=1. Latch fill, src_sel, x0, y0, w, h. Clear col, row, and the address counter.
- IDLE → FLUSH when start=1 and (w==0 or h==0). No address sequence runs and plot never asserts.
- RUN behaviour, each cycle:
  - Present mem_addr = addr counter and increment it.
  - col increments. At col==w-1, col wraps to 0 and row increments.
  - Issue of pixel (w-1, h-1) → FLUSH.
- FLUSH lasts 2 cycles to drain the pipeline, then → DONE.
- DONE lasts 1 cycle with done=1, then → IDLE.
- mem_addr = row*w + col, linear from 0. It is not reset per row.
- Pipeline stage 1: col, row, and the valid flag are delayed 1 cycle to align with ROM data.
- Pipeline stage 2 registers the outputs:
  - x = x0+col and y = y0+row, each computed 1 bit wider than the port, then truncated.
  - color = 0 if fill, else channel src_sel of mem_data.
  - plot = valid & (x0+col < SCREEN_W) & (y0+row < SCREEN_H). The comparison uses the full-width sum, so wrap-around pixels are clipped, not plotted.
- src_sel ≥ NUM_SRC: colour is 0.
- start while busy: ignored, with no effect on latched parameters.
- Reset values (async, resetn=0): state IDLE; mem_addr, x, y, color 0; plot, busy, done 0; all counters and pipeline valids 0.
- resetn asserted mid-RUN: the blit is aborted immediately and no done is produced.

## Timing
- Accepted start at edge 0: busy=1 after edge 0, first mem_addr presented after edge 0.
- First plot asserts after edge 2.
- One pixel per clock with no bubbles.
- Total from start acceptance to done pulse = w*h + 3 cycles (w,h > 0). Zero-size case = 3 cycles.
- Last plot occurs in the cycle before done.
- busy falls in the same cycle done rises.
- A new start is accepted in the cycle after done.
- mem_addr is held at its last value in FLUSH/DONE/IDLE.

## Configuration
- BLIT_TRANSPARENCY_EN defined:
  - In copy mode, a pixel whose colour equals TRANSPARENT is not plotted (plot=0), so sprites overlay backgrounds.
  - Timing and addressing are unchanged.
  - Fill mode ignores transparency and always plots.
- Undefined: every in-bounds pixel is plotted, TRANSPARENT is unused.

## Test plan
- Full-screen copy: start, fill=0, src_sel=2, x0=0, y0=0, w=160, h=120 → 19200 plots; mem_addr 0..19199 in order; x/y raster order; colour = channel 2 delayed 1 cycle; done exactly 19203 cycles after start.
- Sprite with clipping: x0=140, y0=100, w=40, h=40 → only 20×20=400 plots; no plot with x≥160 or y≥120; done after 1603 cycles.
- Fill: fill=1, x0=10, y0=20, w=4, h=3 → 12 plots, colour 0, x 10..13, y 20..22; mem_data ignored.
- Zero size and busy start: w=0, h=5 → no plot, done after 3 cycles. A second start during a 4×4 blit is ignored, and the blit completes unaltered.
- Reset mid-blit: drop resetn 50 cycles into a 40×40 copy → plot/busy/done/x/y/color/mem_addr all 0 immediately; no done pulse; the next start runs a clean blit from mem_addr 0.
- With BLIT_TRANSPARENCY_EN and TRANSPARENT=0: 2×2 copy, ROM data {0,5,0,7} → plots only at pixels 1 and 3 with colours 5 and 7. Without the macro, 4 plots.

Source files
------------

// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
//
// Rectangle blitter for the VGA game datapath. On a start request it walks a
// w x h rectangle in raster order at one pixel per clock. Each pixel is either
// copied from one of NUM_SRC synchronous colour ROMs or filled with black, and
// is sent to the VGA plotter at (x0+col, y0+row). Pixels that land off-screen,
// including ones whose coordinate sum overflows the port width, are clipped.
//
// Ports
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   start              one-cycle request, only looked at while idle
//   fill               1 = black fill, 0 = ROM copy (latched on start)
//   src_sel            ROM channel (latched on start)
//   x0, y0             rectangle origin on screen (latched on start)
//   w, h               rectangle size (latched on start)
//   mem_addr           shared linear address to all ROMs (row*w + col)
//   mem_data           all ROM outputs, channel k at [k*COLOR_W +: COLOR_W],
//                      data arrives one clock after its address
//   x, y, color, plot  plotter write port
//   busy               high from the cycle after an accepted start until done
//   done               one-cycle completion pulse
//
// Configuration macro
//   BLIT_TRANSPARENCY_EN  when defined, copy-mode pixels whose colour equals
//                         TRANSPARENT are not plotted. Fill mode always plots.
// -----------------------------------------------------------------------------
module sprite_blitter #(
   parameter int                 SCREEN_W    = 160,
   parameter int                 SCREEN_H    = 120,
   parameter int                 X_W         = 8,
   parameter int                 Y_W         = 7,
   parameter int                 COLOR_W     = 3,
   parameter int                 ADDR_W      = 15,
   parameter int                 NUM_SRC     = 8,
   parameter int                 SEL_W       = 3,
   parameter logic [COLOR_W-1:0] TRANSPARENT = '0
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       start,
   input  logic                       fill,
   input  logic [SEL_W-1:0]           src_sel,
   input  logic [X_W-1:0]             x0,
   input  logic [Y_W-1:0]             y0,
   input  logic [X_W-1:0]             w,
   input  logic [Y_W-1:0]             h,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic [NUM_SRC*COLOR_W-1:0] mem_data,
   output logic [X_W-1:0]             x,
   output logic [Y_W-1:0]             y,
   output logic [COLOR_W-1:0]         color,
   output logic                       plot,
   output logic                       busy,
   output logic                       done
);

`ifdef BLIT_TRANSPARENCY_EN
   localparam bit LP_TRANSP_EN = 1'b1;
`else
   localparam bit LP_TRANSP_EN = 1'b0;
`endif

   // Screen limits at sum width so the clip test sees overflowed coordinates.
   localparam logic [X_W:0] LP_SCR_W = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] LP_SCR_H = (Y_W+1)'(SCREEN_H);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t              r_state;
   logic                r_flush;     // second FLUSH cycle marker
   logic                r_busy;
   logic                r_done;

   // Parameters captured at start
   logic                r_fill;
   logic [SEL_W-1:0]    r_src_sel;
   logic [X_W-1:0]      r_x0;
   logic [Y_W-1:0]      r_y0;
   logic [X_W-1:0]      r_w;
   logic [Y_W-1:0]      r_h;

   // Issue counters
   logic [X_W-1:0]      r_col;
   logic [Y_W-1:0]      r_row;
   logic [ADDR_W-1:0]   r_addr;

   // Stage 1: issue coordinates delayed to line up with ROM data
   logic                r_s1_vld;
   logic [X_W-1:0]      r_s1_col;
   logic [Y_W-1:0]      r_s1_row;

   // Stage 2: registered plotter outputs
   logic [X_W-1:0]      r_x;
   logic [Y_W-1:0]      r_y;
   logic [COLOR_W-1:0]  r_color;
   logic                r_plot;

   logic                w_last_col;
   logic                w_last_row;
   logic [X_W:0]        w_xsum;
   logic [Y_W:0]        w_ysum;
   logic                w_in_bounds;
   logic                w_drop;
   logic [COLOR_W-1:0]  w_rom;

   assign w_last_col = (r_col == r_w - X_W'(1));
   assign w_last_row = (r_row == r_h - Y_W'(1));

   // -------------------------------------------------------------------------
   // Control FSM: issues one address per RUN cycle, then lets the two-stage
   // pipeline drain before pulsing done.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_flush   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_fill    <= 1'b0;
         r_src_sel <= '0;
         r_x0      <= '0;
         r_y0      <= '0;
         r_w       <= '0;
         r_h       <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_addr    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_fill    <= fill;
                  r_src_sel <= src_sel;
                  r_x0      <= x0;
                  r_y0      <= y0;
                  r_w       <= w;
                  r_h       <= h;
                  r_col     <= '0;
                  r_row     <= '0;
                  r_busy    <= 1'b1;
                  r_flush   <= 1'b0;
                  // An empty rectangle skips the address sweep entirely, so
                  // mem_addr keeps whatever it last showed.
                  if (w == '0 || h == '0) begin
                     r_state <= S_FLUSH;
                  end else begin
                     r_addr  <= '0;
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (w_last_col && w_last_row) begin
                  // Last pixel issued: address stays put through FLUSH/DONE.
                  r_state <= S_FLUSH;
               end else begin
                  r_addr <= r_addr + ADDR_W'(1);
                  if (w_last_col) begin
                     r_col <= '0;
                     r_row <= r_row + Y_W'(1);
                  end else begin
                     r_col <= r_col + X_W'(1);
                  end
               end
            end
            S_FLUSH: begin
               if (r_flush) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_flush <= 1'b1;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // ROM channel select; channels beyond NUM_SRC read as black.
   // -------------------------------------------------------------------------
   always_comb begin
      w_rom = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (r_src_sel == SEL_W'(k)) w_rom = mem_data[k*COLOR_W +: COLOR_W];
      end
   end

   assign w_xsum      = {1'b0, r_x0} + {1'b0, r_s1_col};
   assign w_ysum      = {1'b0, r_y0} + {1'b0, r_s1_row};
   assign w_in_bounds = (w_xsum < LP_SCR_W) && (w_ysum < LP_SCR_H);
   assign w_drop      = LP_TRANSP_EN && !r_fill && (w_rom == TRANSPARENT);

   // -------------------------------------------------------------------------
   // Two-stage output pipeline. Stage 1 waits out the ROM read latency,
   // stage 2 forms the plot coordinates, colour and clip decision.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_s1_vld <= 1'b0;
         r_s1_col <= '0;
         r_s1_row <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_color  <= '0;
         r_plot   <= 1'b0;
      end else begin
         r_s1_vld <= (r_state == S_RUN);
         r_s1_col <= r_col;
         r_s1_row <= r_row;
         r_x      <= w_xsum[X_W-1:0];
         r_y      <= w_ysum[Y_W-1:0];
         r_color  <= r_fill ? '0 : w_rom;
         r_plot   <= r_s1_vld && w_in_bounds && !w_drop;
      end
   end

   assign mem_addr = r_addr;
   assign x        = r_x;
   assign y        = r_y;
   assign color    = r_color;
   assign plot     = r_plot;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// -----------------------------------------------------------------------------
// tb_sprite_blitter
//
// Scoreboard bench for sprite_blitter. A raster-order model of each blit
// (on-screen test, colour lookup from the ROM image) queues the expected
// plotter writes; a monitor pops and compares on every plot. The stimulus
// task also checks mem_addr sequencing, busy, first-plot latency and done
// timing. Six ROM channels are used so that src_sel values 6 and 7 exercise
// the out-of-range channel path.
// -----------------------------------------------------------------------------
module tb_sprite_blitter;

   localparam int NSRC  = 6;
   localparam int DEPTH = 19200;
   localparam int SCR_W = 160;
   localparam int SCR_H = 120;

   typedef struct packed {
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] pc;
   } pix_t;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              start = 1'b0;
   logic              fill = 1'b0;
   logic [2:0]        src_sel = '0;
   logic [7:0]        x0 = '0;
   logic [6:0]        y0 = '0;
   logic [7:0]        w = '0;
   logic [6:0]        h = '0;
   logic [14:0]       mem_addr;
   logic [NSRC*3-1:0] mem_data = '0;
   logic [7:0]        x;
   logic [6:0]        y;
   logic [2:0]        color;
   logic              plot;
   logic              busy;
   logic              done;

   int   checks = 0;
   int   errors = 0;
   int   n_plot = 0;
   pix_t sb[$];
   logic [2:0] rom [NSRC][DEPTH];

   sprite_blitter #(
      .SCREEN_W(SCR_W), .SCREEN_H(SCR_H), .X_W(8), .Y_W(7), .COLOR_W(3),
      .ADDR_W(15), .NUM_SRC(NSRC), .SEL_W(3), .TRANSPARENT(3'b000)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .fill(fill),
      .src_sel(src_sel), .x0(x0), .y0(y0), .w(w), .h(h),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .x(x), .y(y), .color(color), .plot(plot), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous ROM bank, one clock read latency
   always @(posedge clk) begin
      for (int k = 0; k < NSRC; k++)
         mem_data[k*3 +: 3] <= (int'(mem_addr) < DEPTH) ? rom[k][mem_addr] : 3'd0;
   end

   // Monitor: every plotter write must match the head of the scoreboard
   always @(negedge clk) begin : mon
      pix_t got;
      pix_t exp;
      if (resetn && plot) begin
         got = {x, y, color};
         n_plot++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL plot_extra got x=%0d y=%0d c=%0d, none expected", x, y, color);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL plot_pix got x=%0d y=%0d c=%0d, want x=%0d y=%0d c=%0d",
                        x, y, color, exp.px, exp.py, exp.pc);
            end
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference: walk the rectangle in raster order and queue every pixel that
   // should reach the screen.
   task automatic model(input bit f, input int sel, input int bx, input int by,
                        input int bw, input int bh, output int cnt, output bit first_vis);
      int   px, py;
      logic [2:0] c;
      bit   vis;
      cnt = 0;
      first_vis = 1'b0;
      for (int r = 0; r < bh; r++) begin
         for (int cc = 0; cc < bw; cc++) begin
            px = bx + cc;
            py = by + r;
            if (f || sel >= NSRC) c = 3'd0;
            else                  c = rom[sel][r*bw + cc];
            vis = (px < SCR_W) && (py < SCR_H);
`ifdef BLIT_TRANSPARENCY_EN
            if (!f && c == 3'd0) vis = 1'b0;
`endif
            if (vis) begin
               sb.push_back({px[7:0], py[6:0], c});
               cnt++;
               if (r == 0 && cc == 0) first_vis = 1'b1;
            end
         end
      end
   endtask

   // One blit, started in the current cycle (caller sits just after a negedge).
   // Returns one cycle after the done pulse, ready for a back-to-back start.
   task automatic blit(input string tag, input bit f, input int sel, input int bx,
                       input int by, input int bw, input int bh, input bit poke);
      int cnt, n_pix, exp_done, done_k, first_k, addr_bad, busy_bad;
      bit fv;
      model(f, sel, bx, by, bw, bh, cnt, fv);
      n_pix    = bw * bh;
      exp_done = n_pix + 3;
      n_plot   = 0;
      done_k   = -1;
      first_k  = -1;
      addr_bad = 0;
      busy_bad = 0;
      start   = 1'b1;
      fill    = f;
      src_sel = 3'(sel);
      x0      = 8'(bx);
      y0      = 7'(by);
      w       = 8'(bw);
      h       = 7'(bh);
      for (int k = 1; k <= exp_done + 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            // Parameters are latched; scramble the inputs to prove it.
            start   = 1'b0;
            fill    = 1'($urandom);
            src_sel = 3'($urandom);
            x0      = 8'($urandom);
            y0      = 7'($urandom);
            w       = 8'($urandom);
            h       = 7'($urandom);
         end
         if (poke && k == 3) begin
            start = 1'b1;
            w     = 8'd1;
            h     = 7'd1;
         end
         if (poke && k == 4) start = 1'b0;
         if (k - 1 < n_pix) begin
            if (mem_addr !== 15'(k - 1)) addr_bad++;
         end else if (n_pix > 0) begin
            if (mem_addr !== 15'(n_pix - 1)) addr_bad++;
         end
         if (plot && first_k < 0) first_k = k;
         if (done) begin
            done_k = k;
            break;
         end
         if (!busy) busy_bad++;
      end
      chk({tag, "_done_cycles"}, done_k, exp_done);
      chk({tag, "_busy_at_done"}, busy, 0);
      chk({tag, "_busy_low_early"}, busy_bad, 0);
      if (n_pix > 0) chk({tag, "_addr_bad"}, addr_bad, 0);
      if (fv) chk({tag, "_first_plot_cycle"}, first_k, 3);
      chk({tag, "_plot_count"}, n_plot, cnt);
      chk({tag, "_sb_left"}, sb.size(), 0);
      sb.delete();
      @(negedge clk);
      chk({tag, "_done_pulse_len"}, done, 0);
   endtask

   initial begin
      int cnt;
      bit fv;
      for (int k = 0; k < NSRC; k++)
         for (int a = 0; a < DEPTH; a++)
            rom[k][a] = 3'($urandom);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_plot", plot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_color", color, 0);
      chk("rst_addr", mem_addr, 0);
      resetn = 1'b1;
      @(negedge clk);

      // Directed cases
      blit("full", 1'b0, 2, 0, 0, 160, 120, 1'b0);
      blit("clip", 1'b0, 4, 140, 100, 40, 40, 1'b0);
      chk("clip_count_400_max", (n_plot <= 400), 1);
      blit("fill", 1'b1, 3, 10, 20, 4, 3, 1'b0);
      chk("fill_count", n_plot, 12);
      blit("zero", 1'b0, 1, 5, 5, 0, 5, 1'b0);
      chk("zero_count", n_plot, 0);
      blit("busy_start", 1'b0, 0, 30, 30, 4, 4, 1'b1);

      rom[5][0] = 3'd0;
      rom[5][1] = 3'd5;
      rom[5][2] = 3'd0;
      rom[5][3] = 3'd7;
      blit("transp", 1'b0, 5, 10, 10, 2, 2, 1'b0);
`ifdef BLIT_TRANSPARENCY_EN
      chk("transp_count", n_plot, 2);
`else
      chk("transp_count", n_plot, 4);
`endif
      blit("badsel", 1'b0, 7, 20, 20, 3, 3, 1'b0);

      // Reset 50 cycles into a 40x40 copy
      model(1'b0, 1, 0, 0, 40, 40, cnt, fv);
      start = 1'b1; fill = 1'b0; src_sel = 3'd1;
      x0 = 8'd0; y0 = 7'd0; w = 8'd40; h = 7'd40;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("midrst_plot", plot, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_x", x, 0);
      chk("midrst_y", y, 0);
      chk("midrst_color", color, 0);
      chk("midrst_addr", mem_addr, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("midrst_no_done", done, 0);
      end
      blit("post_rst", 1'b0, 0, 0, 0, 8, 8, 1'b0);

      // Random blits, including coordinate wrap-around and clipping
      for (int i = 0; i < 12; i++) begin
         blit("rand", ($urandom_range(0, 5) == 0), $urandom_range(0, 7),
              $urandom_range(0, 255), $urandom_range(0, 127),
              $urandom_range(0, 24), $urandom_range(0, 24), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
